// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU datapath and a loader/debug port.
// Single shared synchronous RAM port; CPU has priority with bounded loader starvation.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int LDR_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [7:0]  ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic        ldr_gnt,
    output logic        ldr_rvalid,
    output logic [15:0] ldr_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        cpu_stall
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RD_CPU = 2'd1;
    localparam logic [1:0] ST_RD_LDR = 2'd2;
    localparam logic [3:0] MAX_WAIT  = 4'(LDR_MAX_WAIT);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_next;
    logic       w_ldr_win;
    logic       w_cpu_gnt;
    logic       w_ldr_gnt;

    // Grants are gated by rst so every output is quiet while reset is held.
    assign w_ldr_win = ldr_req & (~cpu_req | (r_wait_cnt == MAX_WAIT));
    assign w_ldr_gnt = rst & w_ldr_win;
    assign w_cpu_gnt = rst & cpu_req & ~w_ldr_win;

    assign cpu_gnt   = w_cpu_gnt;
    assign ldr_gnt   = w_ldr_gnt;
    assign cpu_stall = rst & cpu_req & ~w_cpu_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 16'h0000;
        if (w_cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_ldr_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end
    end

    always_comb begin
        w_wait_next = 4'd0;
        if (ldr_req && !w_ldr_gnt) begin
            w_wait_next = (r_wait_cnt >= MAX_WAIT) ? MAX_WAIT : r_wait_cnt + 4'd1;
        end
    end

    // The read owner is decided afresh every cycle, so back-to-back reads chain naturally.
    always_comb begin
        w_state_next = ST_IDLE;
        if (w_cpu_gnt && !cpu_we) begin
            w_state_next = ST_RD_CPU;
        end else if (w_ldr_gnt && !ldr_we) begin
            w_state_next = ST_RD_LDR;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    assign cpu_rvalid = (r_state == ST_RD_CPU);
    assign ldr_rvalid = (r_state == ST_RD_LDR);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : 16'h0000;
    assign ldr_rdata  = ldr_rvalid ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural synchronous RAM.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        ldr_req, ldr_we;
    logic [7:0]  ldr_addr;
    logic [15:0] ldr_wdata;
    logic        ldr_gnt, ldr_rvalid;
    logic [15:0] ldr_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        cpu_stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ram [256];

    always #5 clk = ~clk;

    dmem_arbiter #(.LDR_MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
    );

    // RAM preloaded with 0xA000 + address; read data appears one cycle after the strobe.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'hA000 + 16'(i);
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) ram[mem_addr] = mem_wdata;
                else        mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic drive_idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
        ldr_req = 0; ldr_we = 0; ldr_addr = 8'h00; ldr_wdata = 16'h0000;
    endtask

    task automatic test_reset();
        logic [73:0] outs;
        rst = 0;
        drive_idle();
        cpu_req = 1; cpu_addr = 8'h10;
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h33; ldr_wdata = 16'h5555;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            outs = {cpu_gnt, cpu_rvalid, cpu_rdata, ldr_gnt, ldr_rvalid, ldr_rdata,
                    mem_en, mem_we, mem_addr, mem_wdata, cpu_stall};
            n_checks++;
            if (outs !== 74'd0) begin
                n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
            end
        end
        @(negedge clk);
        rst = 1; ldr_req = 0; ldr_we = 0;
        #1;
        n_checks++;
        if ({cpu_gnt, mem_en, mem_we, mem_addr, cpu_stall} !== {1'b1, 1'b1, 1'b0, 8'h10, 1'b0}) begin
            n_fail++; $display("FAIL first_grant: gnt=%b en=%b we=%b addr=%h stall=%b expected 1 1 0 10 0",
                               cpu_gnt, mem_en, mem_we, mem_addr, cpu_stall);
        end
        @(negedge clk);
        cpu_req = 0;
        #1;
        n_checks++;
        if ({cpu_rvalid, cpu_rdata, ldr_rvalid} !== {1'b1, 16'hA010, 1'b0}) begin
            n_fail++; $display("FAIL first_read: rvalid=%b rdata=%h ldr_rvalid=%b expected 1 a010 0",
                               cpu_rvalid, cpu_rdata, ldr_rvalid);
        end
        $display("reset test: cpu read 0x10 -> %h", cpu_rdata);
    endtask

    task automatic test_idle();
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if ({cpu_gnt, ldr_gnt, mem_en, mem_we, mem_addr, mem_wdata, cpu_stall} !== 29'd0) begin
            n_fail++; $display("FAIL idle_outputs: gnt=%b/%b en=%b we=%b addr=%h wdata=%h stall=%b expected all 0",
                               cpu_gnt, ldr_gnt, mem_en, mem_we, mem_addr, mem_wdata, cpu_stall);
        end
        $display("idle test: mem_en=%b", mem_en);
    endtask

    task automatic test_contention();
        logic exp_ldr;
        logic prev_cpu;
        prev_cpu = 0;
        @(negedge clk);
        drive_idle();
        cpu_req = 1; cpu_addr = 8'h20;
        ldr_req = 1; ldr_addr = 8'h30;
        for (int k = 1; k <= 10; k++) begin
            #1;
            exp_ldr = (k % 5 == 0);
            n_checks++;
            if ({ldr_gnt, cpu_gnt, cpu_stall} !== {exp_ldr, ~exp_ldr, exp_ldr}) begin
                n_fail++; $display("FAIL contention_gnt cycle %0d: ldr=%b cpu=%b stall=%b expected %b %b %b",
                                   k, ldr_gnt, cpu_gnt, cpu_stall, exp_ldr, ~exp_ldr, exp_ldr);
            end
            n_checks++;
            if (mem_addr !== (exp_ldr ? 8'h30 : 8'h20)) begin
                n_fail++; $display("FAIL contention_addr cycle %0d: got %h expected %h",
                                   k, mem_addr, exp_ldr ? 8'h30 : 8'h20);
            end
            if (k > 1) begin
                n_checks++;
                if ({cpu_rvalid, ldr_rvalid} !== {prev_cpu, ~prev_cpu}) begin
                    n_fail++; $display("FAIL contention_rvalid cycle %0d: cpu=%b ldr=%b expected %b %b",
                                       k, cpu_rvalid, ldr_rvalid, prev_cpu, ~prev_cpu);
                end
            end
            prev_cpu = ~exp_ldr;
            $display("contention cycle %0d: cpu_gnt=%b ldr_gnt=%b", k, cpu_gnt, ldr_gnt);
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_write_ff();
        @(negedge clk);
        drive_idle();
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'hFF; ldr_wdata = 16'hBEEF;
        #1;
        n_checks++;
        if ({ldr_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, 8'hFF, 16'hBEEF}) begin
            n_fail++; $display("FAIL ldr_write: gnt=%b en=%b we=%b addr=%h wdata=%h expected 1 1 1 ff beef",
                               ldr_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        drive_idle();
        cpu_req = 1; cpu_addr = 8'hFF;
        #1;
        n_checks++;
        if ({ldr_rvalid, cpu_rvalid, cpu_gnt} !== 3'b001) begin
            n_fail++; $display("FAIL write_no_rvalid: ldr_rvalid=%b cpu_rvalid=%b cpu_gnt=%b expected 0 0 1",
                               ldr_rvalid, cpu_rvalid, cpu_gnt);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if ({cpu_rvalid, cpu_rdata, ldr_rvalid} !== {1'b1, 16'hBEEF, 1'b0}) begin
            n_fail++; $display("FAIL read_ff: rvalid=%b rdata=%h ldr_rvalid=%b expected 1 beef 0",
                               cpu_rvalid, cpu_rdata, ldr_rvalid);
        end
        $display("write/read 0xFF: cpu_rdata=%h", cpu_rdata);
    endtask

    task automatic test_addr_zero();
        @(negedge clk);
        drive_idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h00; cpu_wdata = 16'h1234;
        #1;
        n_checks++;
        if ({cpu_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h00, 16'h1234}) begin
            n_fail++; $display("FAIL cpu_write0: gnt=%b we=%b addr=%h wdata=%h expected 1 1 00 1234",
                               cpu_gnt, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        cpu_we = 0; cpu_wdata = 16'h0000;
        #1;
        n_checks++;
        if (cpu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL cpu_write_rvalid: got %b expected 0", cpu_rvalid);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h1234}) begin
            n_fail++; $display("FAIL read0: rvalid=%b rdata=%h expected 1 1234", cpu_rvalid, cpu_rdata);
        end
        $display("write/read 0x00: cpu_rdata=%h", cpu_rdata);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_idle();
        cpu_req = 1; cpu_addr = 8'h01;
        #1;
        n_checks++;
        if (cpu_gnt !== 1'b1) begin
            n_fail++; $display("FAIL b2b_cpu_gnt: got %b expected 1", cpu_gnt);
        end
        @(negedge clk);
        drive_idle();
        ldr_req = 1; ldr_addr = 8'h02;
        #1;
        n_checks++;
        if ({ldr_gnt, cpu_rvalid, cpu_rdata, ldr_rvalid} !== {1'b1, 1'b1, 16'hA001, 1'b0}) begin
            n_fail++; $display("FAIL b2b_n1: ldr_gnt=%b cpu_rvalid=%b cpu_rdata=%h ldr_rvalid=%b expected 1 1 a001 0",
                               ldr_gnt, cpu_rvalid, cpu_rdata, ldr_rvalid);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if ({ldr_rvalid, ldr_rdata, cpu_rvalid, cpu_rdata} !== {1'b1, 16'hA002, 1'b0, 16'h0000}) begin
            n_fail++; $display("FAIL b2b_n2: ldr_rvalid=%b ldr_rdata=%h cpu_rvalid=%b cpu_rdata=%h expected 1 a002 0 0000",
                               ldr_rvalid, ldr_rdata, cpu_rvalid, cpu_rdata);
        end
        $display("back-to-back: ldr_rdata=%h", ldr_rdata);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        drive_idle();
        cpu_req = 1; cpu_addr = 8'h05;
        #1;
        n_checks++;
        if (cpu_gnt !== 1'b1) begin
            n_fail++; $display("FAIL midrst_gnt: got %b expected 1", cpu_gnt);
        end
        #2;
        rst = 0;
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if ({cpu_rvalid, cpu_rdata} !== 17'd0) begin
            n_fail++; $display("FAIL midrst_during: rvalid=%b rdata=%h expected 0 0000", cpu_rvalid, cpu_rdata);
        end
        rst = 1;
        @(negedge clk); #1;
        n_checks++;
        if ({cpu_rvalid, ldr_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL midrst_after: cpu_rvalid=%b ldr_rvalid=%b expected 0 0", cpu_rvalid, ldr_rvalid);
        end
        $display("reset mid-read: cpu_rvalid=%b", cpu_rvalid);
    endtask

    task automatic test_ldr_drop();
        logic exp_ldr;
        @(negedge clk);
        drive_idle();
        cpu_req = 1; cpu_addr = 8'h40;
        ldr_req = 1; ldr_addr = 8'h41;
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_checks++;
            if (ldr_gnt !== 1'b0) begin
                n_fail++; $display("FAIL drop_lose cycle %0d: ldr_gnt=%b expected 0", k, ldr_gnt);
            end
            @(negedge clk);
        end
        ldr_req = 0;
        #1;
        n_checks++;
        if ({cpu_gnt, ldr_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL drop_gap: cpu_gnt=%b ldr_gnt=%b expected 1 0", cpu_gnt, ldr_gnt);
        end
        @(negedge clk);
        ldr_req = 1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            exp_ldr = (k == 5);
            n_checks++;
            if ({ldr_gnt, cpu_gnt} !== {exp_ldr, ~exp_ldr}) begin
                n_fail++; $display("FAIL drop_rewait cycle %0d: ldr_gnt=%b cpu_gnt=%b expected %b %b",
                                   k, ldr_gnt, cpu_gnt, exp_ldr, ~exp_ldr);
            end
            $display("loader re-request cycle %0d: ldr_gnt=%b", k, ldr_gnt);
            @(negedge clk);
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst = 0;
        test_reset();
        test_idle();
        test_contention();
        test_write_ff();
        test_addr_zero();
        test_back_to_back();
        test_reset_mid_read();
        test_ldr_drop();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: LDR_MAX_WAIT, default 4, consecutive lost cycles after which the loader wins unconditionally (range 1-15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 cpu_req  input  1  CPU datapath requests a data-memory access this cycle.
REQ-005 cpu_we  input  1  CPU access is a write when 1, read when 0.
REQ-006 cpu_addr  input  8  CPU word address.
REQ-007 cpu_wdata  input  16  CPU write data.
REQ-008 cpu_gnt  output  1  CPU access is issued to memory this cycle.
REQ-009 cpu_rvalid  output  1  cpu_rdata valid (read issued previous cycle).
REQ-010 cpu_rdata  output  16  CPU read data.
REQ-011 ldr_req, ldr_we, ldr_addr[7:0], ldr_wdata[15:0]  input  loader/debug port request, same meaning as the CPU fields.
REQ-012 ldr_gnt, ldr_rvalid, ldr_rdata[15:0]  output  loader grant, read-valid, read data.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  8  memory address; mem_wdata  output  16  memory write data.
REQ-016 mem_rdata  input  16  memory read data, valid one cycle after a read strobe (synchronous RAM).
REQ-017 cpu_stall  output  1  asserted when cpu_req=1 and cpu_gnt=0; the control path holds state while high.

Function
REQ-018 Grant is combinational from requests and registered state; at most one of cpu_gnt/ldr_gnt is high in any cycle.
REQ-019 Only one requester: that requester is granted the same cycle.
REQ-020 Both requesting: CPU wins unless wait_cnt == LDR_MAX_WAIT, in which case loader wins.
REQ-021 wait_cnt (4 bits): increments when ldr_req=1 and ldr_gnt=0, clears when ldr_gnt=1 or ldr_req=0, saturates at LDR_MAX_WAIT.
REQ-022 Granted cycle: mem_en=1, mem_we/mem_addr/mem_wdata driven from the winner; no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-023 Read ownership FSM, states IDLE, RD_CPU, RD_LDR: next state RD_CPU on granted CPU read, RD_LDR on granted loader read, else IDLE; every state evaluates the same rule (back-to-back reads allowed).
REQ-024 cpu_rvalid=1 exactly in RD_CPU, ldr_rvalid=1 exactly in RD_LDR; the other port's rvalid stays 0.
REQ-025 cpu_rdata/ldr_rdata: mem_rdata when the port's rvalid is 1, else 0.
REQ-026 Writes produce no rvalid; write and read to the same address in consecutive cycles return the new data (RAM behaviour, no forwarding in this block).
REQ-027 Address 0xFF and 0x00 pass unchanged; no address wrap or translation.
REQ-028 A requester whose req drops before grant is forgotten; no queued state beyond wait_cnt.
REQ-029 Read latency: grant cycle N, rvalid and data cycle N+1.

Reset
REQ-030 While rst=0: FSM=IDLE, wait_cnt=0, all outputs 0 (gnt, rvalid, rdata, mem_*, cpu_stall) regardless of inputs.
REQ-031 rst asserted mid-read: pending rvalid is dropped and not reissued after release.
REQ-032 First grant possible in the first clock cycle after rst returns to 1.

Verification
REQ-033 Reset: rst=0 with cpu_req=1 -> all outputs 0; release, cpu read addr 0x10 -> cpu_gnt same cycle, cpu_rvalid next cycle with RAM[0x10].
REQ-034 Contention: cpu_req and ldr_req held high, LDR_MAX_WAIT=4 -> CPU granted 4 cycles, loader cycle 5, cpu_stall=1 in cycle 5, pattern repeats.
REQ-035 Loader write 0xBEEF to 0xFF then CPU read 0xFF -> cpu_rdata=0xBEEF, ldr_rvalid never high.
REQ-036 Back-to-back: CPU read 0x01 then loader read 0x02 -> cpu_rvalid cycle N+1, ldr_rvalid cycle N+2, never both.
REQ-037 Reset mid-read: CPU read granted, rst=0 before next edge -> cpu_rvalid stays 0 through and after reset.
REQ-038 Loader drops ldr_req after 3 lost cycles -> wait_cnt=0 next cycle; new request waits the full LDR_MAX_WAIT again.
